decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 No parameters; all widths fixed (RV32I subset, 32 registers).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 instr_in  input  32  instruction from fetch pipeline register.
REQ-005 pc_plus_4_in  input  32  PC+4 of instr_in.
REQ-006 wb_en  input  1  register-file write enable.
REQ-007 wb_addr  input  5  register-file write address.
REQ-008 wb_data  input  32  register-file write data.
REQ-009 pc_mux_in  output  32  redirect target to fetch, combinational.
REQ-010 pc_select  output  1  redirect request to fetch, combinational.
REQ-011 rs1_data_out, rs2_data_out  output  32 each  registered operands.
REQ-012 imm_out  output  32  registered sign-extended immediate.
REQ-013 rd_out  output  5  registered destination register.
REQ-014 pc_plus_4_out  output  32  registered pc_plus_4_in.
REQ-015 reg_write_out, mem_read_out, mem_write_out, alu_src_out  output  1 each  registered controls.
REQ-016 alu_ctrl_out  output  4  registered ALU select.
REQ-017 wb_sel_out  output  2  registered writeback select: 00 ALU, 01 memory, 10 PC+4, 11 immediate.

Function
REQ-018 Register file SHALL hold 32x32 bits; x0 always reads 0; writes occur on clk edge when wb_en=1 and wb_addr!=0.
REQ-019 Reads SHALL be write-first: if wb_en=1, wb_addr!=0 and wb_addr equals rs1/rs2, the read returns wb_data the same cycle.
REQ-020 Decode SHALL support: R 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BEQ/BNE 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
REQ-021 Immediates SHALL be I/S/B/U/J formats, sign-extended to 32 bits; B and J have bit 0 = 0.
REQ-022 alu_ctrl_out SHALL be {instr[30],funct3} for R-type, {instr[30]&(funct3==101),funct3} for I-ALU, 0000 otherwise.
REQ-023 Controls: R/I-ALU reg_write=1; LW reg_write, mem_read, alu_src=1, wb_sel=01; SW mem_write, alu_src=1; JAL/JALR reg_write, wb_sel=10; LUI reg_write, wb_sel=11.
REQ-024 Branches SHALL resolve in this stage: pc = pc_plus_4_in-4; BEQ taken if rs1==rs2, BNE if rs1!=rs2; other branch funct3 never taken.
REQ-025 pc_select=1 for taken branch, JAL, JALR; pc_mux_in = pc+imm (branch/JAL), (rs1+imm)&~1 (JALR); otherwise pc_select=0 and pc_mux_in=0.
REQ-026 A 1-bit squash flag SHALL be set on the edge where pc_select=1, cleared on every other edge.
REQ-027 While squash=1, instr_in SHALL be treated as a bubble: pc_select=0, no redirect, all controls 0, rd_out=0.
REQ-028 Unsupported opcodes SHALL be bubbles; no redirect.
REQ-029 Bubbles SHALL still latch pc_plus_4_out; register-file writes are unaffected by squash or bubble.
REQ-030 Decode-to-output latency SHALL be exactly one clk edge; no stall input exists.

Reset
REQ-031 rst=1 SHALL immediately clear all registered outputs, squash flag, and all 32 registers to 0, independent of clk.
REQ-032 Reset asserted mid-operation SHALL discard any pending squash; the first instruction after release decodes normally.
REQ-033 Combinational outputs during reset SHALL reflect decode of instr_in with register data 0.

Verification
REQ-034 Write x5=0x0000_0010 via wb port; ADD x7,x5,x5 -> rs1_data_out=rs2_data_out=0x10, reg_write_out=1, rd_out=7, alu_ctrl_out=0000.
REQ-035 BEQ x0,x0,+16 with pc_plus_4_in=0x104 -> pc_select=1, pc_mux_in=0x110; next instr_in produces bubble, pc_select=0.
REQ-036 JALR x1,8(x6), x6=0x203 -> pc_mux_in=0x20A, wb_sel_out=10, rd_out=1.
REQ-037 wb_en=1, wb_addr=3, wb_data=0xDEAD_BEEF, same-cycle ADD reading x3 -> rs1_data_out=0xDEADBEEF; write to x0 -> x0 reads 0.
REQ-038 LW x4,-4(x2) -> imm_out=0xFFFF_FFFC, mem_read_out=1, wb_sel_out=01, alu_src_out=1.
REQ-039 Assert rst between clk edges after taken branch -> outputs and squash 0 immediately; next valid instruction decoded without bubble.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I-subset decode stage: 32x32 register file with write-first bypass,
// immediate/control decode, in-stage branch/jump resolution and a one-cycle squash.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus_4_in,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] pc_mux_in,
    output logic        pc_select,
    output logic [31:0] rs1_data_out,
    output logic [31:0] rs2_data_out,
    output logic [31:0] imm_out,
    output logic [4:0]  rd_out,
    output logic [31:0] pc_plus_4_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        alu_src_out,
    output logic [3:0]  alu_ctrl_out,
    output logic [1:0]  wb_sel_out
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic [31:0] regs_q [32];
    logic        squash_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc;
    logic [31:0] rs1_val, rs2_val;

    assign opcode = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign rd     = instr_in[11:7];
    assign rs1    = instr_in[19:15];
    assign rs2    = instr_in[24:20];
    assign imm_i  = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s  = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b  = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u  = {instr_in[31:12], 12'b0};
    assign imm_j  = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
    assign pc     = pc_plus_4_in - 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wb_en && wb_addr != 5'd0) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Write-first bypass; register data reads as zero while reset is held.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (!rst && rs1 != 5'd0) rs1_val = (wb_en && wb_addr == rs1) ? wb_data : regs_q[rs1];
        if (!rst && rs2 != 5'd0) rs2_val = (wb_en && wb_addr == rs2) ? wb_data : regs_q[rs2];
    end

    logic        dec_valid, rw_d, mr_d, mw_d, as_d, redirect;
    logic [3:0]  alu_d;
    logic [1:0]  wb_d;
    logic [31:0] imm_d, target;

    always_comb begin
        dec_valid = 1'b0;
        rw_d      = 1'b0;
        mr_d      = 1'b0;
        mw_d      = 1'b0;
        as_d      = 1'b0;
        alu_d     = 4'b0000;
        wb_d      = 2'b00;
        imm_d     = '0;
        redirect  = 1'b0;
        target    = '0;
        if (!squash_q) begin
            unique case (opcode)
                OP_R: begin
                    dec_valid = 1'b1;
                    rw_d      = 1'b1;
                    alu_d     = {instr_in[30], funct3};
                end
                OP_I: begin
                    dec_valid = 1'b1;
                    rw_d      = 1'b1;
                    alu_d     = {instr_in[30] & (funct3 == 3'b101), funct3};
                    imm_d     = imm_i;
                end
                OP_LW: begin
                    dec_valid = 1'b1;
                    rw_d      = 1'b1;
                    mr_d      = 1'b1;
                    as_d      = 1'b1;
                    wb_d      = 2'b01;
                    imm_d     = imm_i;
                end
                OP_SW: begin
                    dec_valid = 1'b1;
                    mw_d      = 1'b1;
                    as_d      = 1'b1;
                    imm_d     = imm_s;
                end
                OP_BR: begin
                    dec_valid = 1'b1;
                    imm_d     = imm_b;
                    target    = pc + imm_b;
                    redirect  = (funct3 == 3'b000 && rs1_val == rs2_val) ||
                                (funct3 == 3'b001 && rs1_val != rs2_val);
                end
                OP_JAL: begin
                    dec_valid = 1'b1;
                    rw_d      = 1'b1;
                    wb_d      = 2'b10;
                    imm_d     = imm_j;
                    target    = pc + imm_j;
                    redirect  = 1'b1;
                end
                OP_JALR: begin
                    dec_valid = 1'b1;
                    rw_d      = 1'b1;
                    wb_d      = 2'b10;
                    imm_d     = imm_i;
                    target    = (rs1_val + imm_i) & ~32'd1;
                    redirect  = 1'b1;
                end
                OP_LUI: begin
                    dec_valid = 1'b1;
                    rw_d      = 1'b1;
                    wb_d      = 2'b11;
                    imm_d     = imm_u;
                end
                default: ;
            endcase
        end
    end

    assign pc_select = redirect;
    assign pc_mux_in = redirect ? target : 32'd0;

    // Bubbles (squashed or unsupported) flush operands too; only pc_plus_4 survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            squash_q      <= 1'b0;
            rs1_data_out  <= '0;
            rs2_data_out  <= '0;
            imm_out       <= '0;
            rd_out        <= '0;
            pc_plus_4_out <= '0;
            reg_write_out <= 1'b0;
            mem_read_out  <= 1'b0;
            mem_write_out <= 1'b0;
            alu_src_out   <= 1'b0;
            alu_ctrl_out  <= '0;
            wb_sel_out    <= '0;
        end else begin
            squash_q      <= redirect;
            rs1_data_out  <= dec_valid ? rs1_val : 32'd0;
            rs2_data_out  <= dec_valid ? rs2_val : 32'd0;
            imm_out       <= imm_d;
            rd_out        <= rw_d ? rd : 5'd0;
            pc_plus_4_out <= pc_plus_4_in;
            reg_write_out <= rw_d;
            mem_read_out  <= mr_d;
            mem_write_out <= mw_d;
            alu_src_out   <= as_d;
            alu_ctrl_out  <= alu_d;
            wb_sel_out    <= wb_d;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected register-stage results are queued
// when an instruction is driven and compared one edge later.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in, pc_plus_4_in, wb_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] pc_mux_in, rs1_data_out, rs2_data_out, imm_out, pc_plus_4_out;
    logic        pc_select, reg_write_out, mem_read_out, mem_write_out, alu_src_out;
    logic [4:0]  rd_out;
    logic [3:0]  alu_ctrl_out;
    logic [1:0]  wb_sel_out;

    decode_stage dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_plus_4_in(pc_plus_4_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pc_mux_in(pc_mux_in), .pc_select(pc_select),
        .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out), .imm_out(imm_out),
        .rd_out(rd_out), .pc_plus_4_out(pc_plus_4_out), .reg_write_out(reg_write_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .alu_src_out(alu_src_out),
        .alu_ctrl_out(alu_ctrl_out), .wb_sel_out(wb_sel_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [3:0]  ctl;   // {reg_write, mem_read, mem_write, alu_src}
        logic [3:0]  alu;
        logic [1:0]  wb;
    } out_t;

    typedef struct packed {
        out_t o;
        logic bub;
    } sb_t;

    sb_t  sbq [$];
    out_t obs;
    int   n_tests = 0;
    int   n_fail  = 0;

    assign obs = {rs1_data_out, rs2_data_out, imm_out, pc_plus_4_out, rd_out,
                  reg_write_out, mem_read_out, mem_write_out, alu_src_out,
                  alu_ctrl_out, wb_sel_out};

    localparam logic [3:0] RW  = 4'b1000;
    localparam logic [3:0] LWC = 4'b1101;
    localparam logic [3:0] SWC = 4'b0011;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, r1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {im, r1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2, r1);
        return {im[11:5], r2, r1, 3'b010, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] r2, r1,
                                          input logic [2:0] f3);
        return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rd);
        return {im, rd, 7'b0110111};
    endfunction

    function automatic out_t mk(input logic [31:0] r1, r2, im, p4, input logic [4:0] rd,
                                input logic [3:0] c, input logic [3:0] alu, input logic [1:0] wb);
        return {r1, r2, im, p4, rd, c, alu, wb};
    endfunction

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one instruction, check the combinational redirect, then compare the
    // registered result popped from the scoreboard after the next rising edge.
    task automatic step(input string tag, input logic [31:0] ins, p4,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic exp_sel, input logic [31:0] exp_mux,
                        input out_t exp, input logic bub);
        sb_t  e;
        out_t g;
        @(negedge clk);
        instr_in = ins; pc_plus_4_in = p4; wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        check({tag, "_sel"}, {159'd0, pc_select}, {159'd0, exp_sel});
        check({tag, "_mux"}, {128'd0, pc_mux_in}, {128'd0, exp_mux});
        sbq.push_back('{o: exp, bub: bub});
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        if (sbq.size() == 0) begin
            check({tag, "_sbq_empty"}, 160'd1, 160'd0);
        end else begin
            e = sbq.pop_front();
            g = obs;
            if (e.bub) begin
                e.o.rs1 = '0; e.o.rs2 = '0; e.o.imm = '0;
                g.rs1   = '0; g.rs2   = '0; g.imm   = '0;
            end
            check({tag, "_out"}, {17'd0, g}, {17'd0, e.o});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        instr_in = enc_j(21'd8, 5'd1); pc_plus_4_in = 32'h100;
        #2;
        check("reset_out", {17'd0, obs}, 160'd0);
        check("reset_comb_sel", {159'd0, pc_select}, 160'd1);
        check("reset_comb_mux", {128'd0, pc_mux_in}, 160'h104);
        repeat (2) @(posedge clk);
        @(negedge clk);
        instr_in = '0;
        rst = 1'b0;

        step("bub_wr5", 32'h0, 32'h4, 1'b1, 5'd5, 32'h10, 1'b0, 32'h0, mk(0, 0, 0, 32'h4, 0, 0, 0, 0), 1'b1);
        step("add",  enc_r(7'h00, 5, 5, 3'b000, 7), 32'h8, 0, 0, 0, 0, 0, mk(32'h10, 32'h10, 0, 32'h8, 7, RW, 4'b0000, 2'b00), 0);
        step("sub",  enc_r(7'h20, 5, 5, 3'b000, 8), 32'hC, 0, 0, 0, 0, 0, mk(32'h10, 32'h10, 0, 32'hC, 8, RW, 4'b1000, 2'b00), 0);
        step("srai", enc_i(12'h403, 5, 3'b101, 9, 7'b0010011), 32'h10, 0, 0, 0, 0, 0,
             mk(32'h10, 0, 32'h403, 32'h10, 9, RW, 4'b1101, 2'b00), 0);
        step("bypass", enc_r(7'h00, 0, 3, 3'b000, 10), 32'h14, 1, 3, 32'hDEADBEEF, 0, 0,
             mk(32'hDEADBEEF, 0, 0, 32'h14, 10, RW, 0, 0), 0);
        step("wr_x0", enc_r(7'h00, 3, 0, 3'b000, 11), 32'h18, 1, 0, 32'h1234, 0, 0,
             mk(0, 32'hDEADBEEF, 0, 32'h18, 11, RW, 0, 0), 0);
        step("x0_zero", enc_r(7'h00, 0, 0, 3'b000, 12), 32'h1C, 0, 0, 0, 0, 0, mk(0, 0, 0, 32'h1C, 12, RW, 0, 0), 0);
        step("bub_wr6", 32'h0, 32'h20, 1, 6, 32'h203, 0, 0, mk(0, 0, 0, 32'h20, 0, 0, 0, 0), 1);
        step("jalr", enc_i(12'd8, 6, 3'b000, 1, 7'b1100111), 32'h40, 0, 0, 0, 1, 32'h20A,
             mk(32'h203, 0, 32'h8, 32'h40, 1, RW, 0, 2'b10), 0);
        step("jalr_squash", enc_r(7'h00, 5, 5, 3'b000, 7), 32'h44, 0, 0, 0, 0, 0, mk(0, 0, 0, 32'h44, 0, 0, 0, 0), 1);
        step("post_squash", enc_r(7'h00, 5, 5, 3'b000, 7), 32'h48, 0, 0, 0, 0, 0,
             mk(32'h10, 32'h10, 0, 32'h48, 7, RW, 0, 0), 0);
        step("lw", enc_i(12'hFFC, 2, 3'b010, 4, 7'b0000011), 32'h4C, 0, 0, 0, 0, 0,
             mk(0, 0, 32'hFFFFFFFC, 32'h4C, 4, LWC, 0, 2'b01), 0);
        step("sw", enc_s(12'd12, 5, 6), 32'h50, 0, 0, 0, 0, 0, mk(32'h203, 32'h10, 32'hC, 32'h50, 0, SWC, 0, 0), 0);
        step("lui", enc_u(20'hFE007, 13), 32'h54, 0, 0, 0, 0, 0, mk(0, 0, 32'hFE007000, 32'h54, 13, RW, 0, 2'b11), 0);
        step("beq", enc_b(13'd16, 0, 0, 3'b000), 32'h104, 0, 0, 0, 1, 32'h110, mk(0, 0, 32'h10, 32'h104, 0, 0, 0, 0), 0);
        step("beq_squash", enc_r(7'h00, 5, 5, 3'b000, 7), 32'h108, 0, 0, 0, 0, 0, mk(0, 0, 0, 32'h108, 0, 0, 0, 0), 1);
        step("bne", enc_b(13'h1FF8, 0, 5, 3'b001), 32'h200, 0, 0, 0, 1, 32'h1F4,
             mk(32'h10, 0, 32'hFFFFFFF8, 32'h200, 0, 0, 0, 0), 0);

        // Reset between edges while a squash is pending.
        @(negedge clk);
        instr_in = enc_r(7'h00, 5, 5, 3'b000, 7); pc_plus_4_in = 32'h300;
        rst = 1'b1;
        #1;
        check("midrst_out", {17'd0, obs}, 160'd0);
        check("midrst_sel", {159'd0, pc_select}, 160'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        step("after_rst", enc_r(7'h00, 5, 5, 3'b000, 7), 32'h300, 0, 0, 0, 0, 0, mk(0, 0, 0, 32'h300, 7, RW, 0, 0), 0);
        step("blt_never", enc_b(13'd16, 0, 0, 3'b100), 32'h304, 0, 0, 0, 0, 0, mk(0, 0, 32'h10, 32'h304, 0, 0, 0, 0), 0);
        step("unsupported", 32'hFFFFFFFF, 32'h308, 0, 0, 0, 0, 0, mk(0, 0, 0, 32'h308, 0, 0, 0, 0), 1);
        step("after_unsup", enc_r(7'h00, 5, 5, 3'b000, 7), 32'h30C, 0, 0, 0, 0, 0, mk(0, 0, 0, 32'h30C, 7, RW, 0, 0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
